// File: rtl/ftdi_tx_arbiter_pkg.sv
// Shared types and helpers for the FTDI transmit arbiter: FSM encoding,
// counter width and a constant-friendly clog2.
package ftdi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UP_ACK  = 3'd1,
    ST_DN_REQ  = 3'd2,
    ST_DN_WAIT = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  localparam int CNT_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ftdi_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap,
// or only considers the lock owner while a packet lock is held.
module rr_pick
  import ftdi_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          lock_en,
  input  logic [IW-1:0] lock_owner,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    if (lock_en) begin
      valid = req[lock_owner];
      idx   = lock_owner;
    end else begin
      // k = N wraps back to ptr itself, so the last winner is considered last.
      for (int k = 1; k <= N; k++) begin
        cand = int'(ptr) + k;
        if (cand >= N) cand = cand - N;
        if (!valid && req[cand[IW-1:0]]) begin
          valid = 1'b1;
          idx   = cand[IW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Shares the single ftdi transmit channel among N byte sources with
// round-robin arbitration, optional packet lock and a transfer watchdog.
module ftdi_tx_arbiter
  import ftdi_arb_pkg::*;
#(
  parameter int N            = 3,
  parameter int GAP          = 2,
  parameter int TIMEOUT      = 0,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic           clock_in,
  input  logic           reset,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_rq,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_st,
  output logic [N-1:0]   grant,
  output logic [7:0]     tx_data,
  output logic           tx_rq,
  input  logic           tx_st,
  output logic           busy,
  output logic           err
);

  localparam int IW = clog2(N);
  localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_C    = CNT_W'(LOCK_TIMEOUT);

  // Handshakes are four-phase: upstream req_rq is held until req_st rises,
  // then dropped, after which req_st falls; downstream tx_rq is held until
  // tx_st rises, dropped, and the next byte waits for tx_st to fall plus GAP.

  state_e             state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_rq_q, tx_rq_d;
  logic [N-1:0]       req_st_q, req_st_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               last_q, last_d;
  logic               lock_en_q, lock_en_d;
  logic [IW-1:0]      lock_owner_q, lock_owner_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   lock_cnt_inc;
  logic               timeout_hit;
  logic               gap_done;
  logic               lock_idle;
  logic               lock_expire;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req        (req_rq),
    .ptr        (ptr_q),
    .lock_en    (lock_en_q),
    .lock_owner (lock_owner_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign lock_cnt_inc = lock_cnt_q + CNT_W'(1);
  assign timeout_hit  = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_C);
  assign gap_done     = (cnt_inc >= GAP_C);
  assign lock_idle    = (state_q == ST_IDLE) && lock_en_q && !req_rq[lock_owner_q];
  assign lock_expire  = (LOCK_TIMEOUT != 0) && lock_idle && (lock_cnt_inc >= LOCK_C);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tx_data_q    <= '0;
      tx_rq_q      <= 1'b0;
      req_st_q     <= '0;
      grant_q      <= '0;
      ptr_q        <= IW'(N - 1);
      owner_q      <= '0;
      last_q       <= 1'b0;
      lock_en_q    <= 1'b0;
      lock_owner_q <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_rq_q      <= tx_rq_d;
      req_st_q     <= req_st_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      lock_en_q    <= lock_en_d;
      lock_owner_q <= lock_owner_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pick_valid) state_d = ST_UP_ACK;
      ST_UP_ACK:  if (!req_rq[owner_q]) state_d = ST_DN_REQ;
      ST_DN_REQ: begin
        if (tx_st) state_d = ST_DN_WAIT;
        else if (timeout_hit) state_d = ST_GAP;
      end
      ST_DN_WAIT: if (!tx_st) state_d = ST_GAP;
      ST_GAP:     if (gap_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_data_d    = tx_data_q;
    tx_rq_d      = tx_rq_q;
    req_st_d     = req_st_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    last_d       = last_q;
    lock_en_d    = lock_en_q;
    lock_owner_d = lock_owner_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    lock_cnt_d   = lock_idle ? lock_cnt_inc : '0;

    // An owner that stays silent too long forfeits the lock without an error.
    if (lock_expire) begin
      lock_en_d  = 1'b0;
      lock_cnt_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          tx_data_d = req_data[{pick_idx, 3'b000} +: 8];
          req_st_d  = N'(1) << pick_idx;
          grant_d   = N'(1) << pick_idx;
          ptr_d     = pick_idx;
          owner_d   = pick_idx;
          last_d    = req_last[pick_idx];
        end
      end
      ST_UP_ACK: begin
        if (!req_rq[owner_q]) begin
          req_st_d = '0;
          tx_rq_d  = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_DN_REQ: begin
        cnt_d = cnt_inc;
        if (tx_st) begin
          tx_rq_d = 1'b0;
        end else if (timeout_hit) begin
          // Byte is dropped; a half-sent packet must not keep the channel.
          tx_rq_d   = 1'b0;
          err_d     = 1'b1;
          lock_en_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ST_DN_WAIT: begin
        if (!tx_st) begin
          cnt_d = '0;
          if (last_q) begin
            lock_en_d = 1'b0;
          end else begin
            lock_en_d    = 1'b1;
            lock_owner_d = owner_q;
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_inc;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign tx_data = tx_data_q;
  assign tx_rq   = tx_rq_q;
  assign req_st  = req_st_q;
  assign grant   = grant_q;
  assign busy    = (state_q != ST_IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Directed bench for ftdi_tx_arbiter: table of multi-requester scenarios
// plus hand-written sequences for latency, lock timeout, watchdog and reset.
module tb_ftdi_tx_arbiter;

  localparam int N            = 3;
  localparam int GAP          = 2;
  localparam int TIMEOUT      = 16;
  localparam int LOCK_TIMEOUT = 8;

  logic           clock_in;
  logic           reset;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_rq;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_st;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_rq;
  logic           tx_st;
  logic           busy;
  logic           err;

  ftdi_tx_arbiter #(
    .N            (N),
    .GAP          (GAP),
    .TIMEOUT      (TIMEOUT),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .req_data (req_data),
    .req_rq   (req_rq),
    .req_last (req_last),
    .req_st   (req_st),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_rq    (tx_rq),
    .tx_st    (tx_st),
    .busy     (busy),
    .err      (err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];          // {grant, tx_data} in capture order
  logic [8:0]  src_mem [N][32];   // {last, data} per requester
  int          src_cnt [N];
  int          src_idx [N];
  bit          stall;

  typedef struct packed {
    logic [2:0][2:0][8:0] src;
    logic [2:0][1:0]      cnt;
    logic [5:0][10:0]     exp;
    logic [2:0]           n_exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(negedge clock_in);
    #1;
  endtask

  task automatic load(input int r, input logic [8:0] v);
    src_mem[r][src_cnt[r]] = v;
    src_cnt[r]++;
  endtask

  function automatic bit srcs_done();
    bit d;
    d = 1'b1;
    for (int r = 0; r < N; r++) if (src_idx[r] != src_cnt[r]) d = 1'b0;
    return d;
  endfunction

  task automatic wait_idle(input string name);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      tick();
      cyc++;
      done = srcs_done() && (exp_q.size() == 0) && !busy && !tx_rq;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: not drained after %0d cycles, %0d bytes outstanding", name, cyc,
               exp_q.size());
    end
  endtask

  // ---------------- requester drivers ----------------
  initial begin
    req_rq   = '0;
    req_last = '0;
    req_data = '0;
    for (int r = 0; r < N; r++) begin
      src_cnt[r] = 0;
      src_idx[r] = 0;
    end
    forever begin
      @(negedge clock_in);
      for (int i = 0; i < N; i++) begin
        if (req_rq[i] && req_st[i]) begin
          req_rq[i] = 1'b0;
          src_idx[i]++;
        end else if (!req_rq[i] && !req_st[i] && src_idx[i] < src_cnt[i]) begin
          req_data[i*8 +: 8] = src_mem[i][src_idx[i]][7:0];
          req_last[i]        = src_mem[i][src_idx[i]][8];
          req_rq[i]          = 1'b1;
        end
      end
    end
  end

  // ---------------- ftdi model + scoreboard ----------------
  int dly    = 0;
  int lowcnt = 0;
  bit armed  = 1'b0;

  initial begin
    tx_st = 1'b0;
    forever begin
      @(negedge clock_in);
      if (reset) begin
        tx_st = 1'b0;
        dly   = 0;
        armed = 1'b0;
      end else if (tx_st) begin
        if (!tx_rq) begin
          tx_st  = 1'b0;
          armed  = 1'b1;
          lowcnt = 0;
        end
      end else if (tx_rq) begin
        if (armed) begin
          chk_range("tx_rq_gap", lowcnt, GAP, 1000);
          armed = 1'b0;
        end
        if (!stall) begin
          dly++;
          if (dly == 3) begin
            dly   = 0;
            tx_st = 1'b1;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL tx_byte: got 0x%0h, expected no byte", {grant, tx_data});
            end else begin
              chk("tx_byte", {21'd0, grant, tx_data}, {21'd0, exp_q.pop_front()});
            end
          end
        end
      end else if (armed) begin
        lowcnt++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int n;

  initial begin
    reset = 1'b1;
    stall = 1'b0;

    // Scenario table. Entries are {last, data}; expectations are {grant, data}.
    for (int v = 0; v < 5; v++) vecs[v] = '0;
    // Round robin from reset pointer: 0x10, 0x20, 0x30, then 0x10 again.
    vecs[0].src[0][0] = 9'h110; vecs[0].src[0][1] = 9'h110; vecs[0].cnt[0] = 2'd2;
    vecs[0].src[1][0] = 9'h120; vecs[0].cnt[1] = 2'd1;
    vecs[0].src[2][0] = 9'h130; vecs[0].cnt[2] = 2'd1;
    vecs[0].exp[0] = 11'h110; vecs[0].exp[1] = 11'h220;
    vecs[0].exp[2] = 11'h430; vecs[0].exp[3] = 11'h110; vecs[0].n_exp = 3'd4;
    // Lone requester 2 moves the pointer to 2.
    vecs[1].src[2][0] = 9'h144; vecs[1].cnt[2] = 2'd1;
    vecs[1].exp[0] = 11'h444; vecs[1].n_exp = 3'd1;
    // Packet lock: 01,02,03 from requester 0 before requester 2's 0x99.
    vecs[2].src[0][0] = 9'h001; vecs[2].src[0][1] = 9'h002; vecs[2].src[0][2] = 9'h103;
    vecs[2].cnt[0] = 2'd3;
    vecs[2].src[2][0] = 9'h199; vecs[2].cnt[2] = 2'd1;
    vecs[2].exp[0] = 11'h101; vecs[2].exp[1] = 11'h102;
    vecs[2].exp[2] = 11'h103; vecs[2].exp[3] = 11'h499; vecs[2].n_exp = 3'd4;
    // Unlocked re-request from 0 yields to 1 first.
    vecs[3].src[0][0] = 9'h1A0; vecs[3].src[0][1] = 9'h1A1; vecs[3].cnt[0] = 2'd2;
    vecs[3].src[1][0] = 9'h1B0; vecs[3].cnt[1] = 2'd1;
    vecs[3].exp[0] = 11'h1A0; vecs[3].exp[1] = 11'h2B0; vecs[3].exp[2] = 11'h1A1;
    vecs[3].n_exp = 3'd3;
    // Two-byte packet on requester 1, then rotation continues 2, 0.
    vecs[4].src[1][0] = 9'h0C1; vecs[4].src[1][1] = 9'h1C2; vecs[4].cnt[1] = 2'd2;
    vecs[4].src[0][0] = 9'h1D0; vecs[4].cnt[0] = 2'd1;
    vecs[4].src[2][0] = 9'h1E2; vecs[4].cnt[2] = 2'd1;
    vecs[4].exp[0] = 11'h2C1; vecs[4].exp[1] = 11'h2C2;
    vecs[4].exp[2] = 11'h4E2; vecs[4].exp[3] = 11'h1D0; vecs[4].n_exp = 3'd4;

    // Reset state.
    repeat (3) tick();
    chk("rst_tx_rq", {31'd0, tx_rq}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_req_st", {29'd0, req_st}, 32'd0);
    chk("rst_grant", {29'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven scenarios.
    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < N; r++) begin
        for (int s = 0; s < int'(vecs[v].cnt[r]); s++) load(r, vecs[v].src[r][s]);
      end
      for (int e = 0; e < int'(vecs[v].n_exp); e++) exp_q.push_back(vecs[v].exp[e]);
      wait_idle($sformatf("vec%0d_drain", v));
    end
    chk("err_after_table", {31'd0, err}, 32'd0);

    // Single byte from requester 1: req_st one cycle after req_rq.
    load(1, 9'h1A5);
    exp_q.push_back(11'h2A5);
    n = 0;
    do begin tick(); n++; end while (!req_rq[1] && n < 20);
    chk("single_req_rq_seen", {31'd0, req_rq[1]}, 32'd1);
    chk("single_req_st_before", {31'd0, req_st[1]}, 32'd0);
    tick();
    chk("single_req_st", {29'd0, req_st}, 32'b010);
    chk("single_grant", {29'd0, grant}, 32'b010);
    chk("single_tx_data", {24'd0, tx_data}, 32'hA5);
    chk("single_busy", {31'd0, busy}, 32'd1);
    wait_idle("single_drain");
    chk("single_grant_held", {29'd0, grant}, 32'b010);
    chk("single_tx_data_held", {24'd0, tx_data}, 32'hA5);

    // Lock timeout: requester 0 leaves a packet open, requester 1 waits.
    load(0, 9'h001);
    load(1, 9'h155);
    exp_q.push_back(11'h101);
    exp_q.push_back(11'h255);
    n = 0;
    do begin tick(); n++; end while (!busy && n < 50);
    n = 0;
    do begin tick(); n++; end while (busy && n < 100);
    n = 1;
    tick();
    while (!busy && n < 100) begin
      n++;
      tick();
    end
    chk_range("lock_timeout_idle", n, LOCK_TIMEOUT, LOCK_TIMEOUT + 2);
    chk("lock_timeout_grant", {29'd0, grant}, 32'b010);
    wait_idle("lock_timeout_drain");
    chk("lock_timeout_err", {31'd0, err}, 32'd0);

    // Transfer timeout: ftdi never answers.
    stall = 1'b1;
    load(2, 9'h166);
    n = 0;
    do begin tick(); n++; end while (!tx_rq && n < 50);
    chk("wdog_err_before", {31'd0, err}, 32'd0);
    n = 1;
    tick();
    while (tx_rq && n < 100) begin
      n++;
      tick();
    end
    chk("wdog_rq_cycles", n, TIMEOUT);
    chk("wdog_err", {31'd0, err}, 32'd1);
    stall = 1'b0;
    wait_idle("wdog_drain");
    load(2, 9'h177);
    exp_q.push_back(11'h477);
    wait_idle("wdog_next_drain");
    chk("wdog_err_sticky", {31'd0, err}, 32'd1);

    // Reset while in DN_REQ with all three requesters pending.
    stall = 1'b1;
    load(1, 9'h111);
    n = 0;
    do begin tick(); n++; end while (!tx_rq && n < 50);
    load(0, 9'h10A);
    load(1, 9'h11B);
    load(2, 9'h12C);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_tx_rq", {31'd0, tx_rq}, 32'd0);
    chk("mid_rst_req_st", {29'd0, req_st}, 32'd0);
    chk("mid_rst_grant", {29'd0, grant}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    exp_q.push_back(11'h10A);
    exp_q.push_back(11'h21B);
    exp_q.push_back(11'h42C);
    wait_idle("post_rst_drain");
    chk("post_rst_err", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ftdi_tx_arbiter.md
Name: ftdi_tx_arbiter

Overview:
- Shares the single FTDI transmit channel (the `tx_data`/`tx_rq`/`tx_st` side of `ftdi`) among N on-chip byte sources, e.g. the command-response path, a streaming source and a debug port.
- Arbitration is round-robin, with an optional packet lock so that multi-byte messages are not interleaved.
- Drives `ftdi`'s four-phase `tx_rq`/`tx_st` handshake, enforces the low gap `ftdi` needs to return to idle, and flags stalled transfers.

Parameters:
- N, 3: number of requesters (2..8).
- GAP, 2: minimum cycles `tx_rq` is held low between bytes (≥2, because `ftdi` registers `tx_rq`).
- TIMEOUT, 0: max cycles in DN_REQ waiting for `tx_st`; 0 = disabled.
- LOCK_TIMEOUT, 1024: max idle cycles a lock owner may hold the channel before the lock is released; 0 = never release.

Ports:
- clock_in  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clock_in.
- req_data  in  8*N  byte from requester i in bits [8i+7:8i].
- req_rq  in  N  requester i has a byte; held until its `req_st` rises.
- req_last  in  N  byte is the last of a packet; sampled together with `req_data`.
- req_st  out  N  byte captured; falls after `req_rq` falls.
- grant  out  N  one-hot, current/last granted requester.
- tx_data  out  8  byte to `ftdi`.
- tx_rq  out  1  request to `ftdi`.
- tx_st  in  1  `ftdi` capture strobe.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky: a transfer timed out; cleared only by reset.

Behaviour:
- Reset: state=IDLE; `tx_rq`=0, `tx_data`=0, `req_st`=0, `grant`=0, `busy`=0, `err`=0; lock cleared; RR pointer = N-1, so requester 0 has first priority.
- Reset mid-transfer: outputs go to reset values on the next edge. A byte already captured from a requester is lost.
- All inputs are in the `clock_in` domain; no synchronisers.
- IDLE:
  - If locked, only the lock owner is eligible; otherwise pick the first asserted `req_rq` searching from pointer+1 upward, with wrap-around.
  - On a pick of i at edge t:
    - `tx_data` ← `req_data[i]`
    - `req_st[i]` ← 1
    - `grant` ← onehot(i), pointer ← i
    - last_q ← `req_last[i]`
    - go to UP_ACK
  - `req_st` is visible at t+1.
- UP_ACK: wait `req_rq[i]`==0, then `req_st[i]` ← 0, `tx_rq` ← 1, go to DN_REQ.
- DN_REQ:
  - When `tx_st`==1: `tx_rq` ← 0, go to DN_WAIT.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT: `tx_rq` ← 0, `err` ← 1, byte dropped, lock cleared, go to GAP.
  - The counter resets on entry to DN_REQ.
- DN_WAIT: wait `tx_st`==0, then go to GAP. Lock update: if last_q=0, lock ← owner i; else lock cleared.
- GAP: hold `tx_rq`=0 for GAP cycles, then go to IDLE.
- Lock timeout: while locked in IDLE with `req_rq[owner]`=0 for LOCK_TIMEOUT cycles, the lock is cleared; `err` is not set.
- Simultaneous requests: resolved only by the RR order; after granting i, i has lowest priority at the next non-locked pick.
- `req_rq` pulses shorter than one sample are not guaranteed to be seen. A requester must hold `req_rq` until `req_st` rises.
- Minimum cost per byte: 1 (IDLE) + 1 (UP_ACK, if `req_rq` drops immediately) + `ftdi` latency + GAP cycles.
- `tx_data` is stable from the pick until the next pick.

Decomposition:
- Package ftdi_arb_pkg holds:
  - state encoding (IDLE, UP_ACK, DN_REQ, DN_WAIT, GAP), 3 bits
  - counter width (16)
  - function clog2
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs: N-bit request vector, pointer, lock enable, lock owner. Outputs: valid and index.
- The main module holds the FSM, counters, lock and the output registers.

Test Plan:
- Single byte: `req_rq[1]`=1, `req_data`=0xA5, `req_last`=1; bench `ftdi` model raises `tx_st` 3 cycles after `tx_rq`. Required:
  - `req_st[1]` rises 1 cycle after `req_rq`
  - `tx_data`=0xA5, `grant`=3'b010
  - `tx_rq` held low ≥2 cycles after `tx_st` falls
  - `busy` falls at IDLE
- Round-robin: all three `req_rq` held high, each with `req_last`=1, bytes 0x10/0x20/0x30 re-presented after each ack → `tx_data` order 0x10, 0x20, 0x30, 0x10; `grant` sequence 001, 010, 100, 001.
- Packet lock:
  - Requester 0 sends 0x01 (last=0), 0x02 (last=0), 0x03 (last=1) while requester 2 continuously requests 0x99.
  - Required `tx_data` order: 0x01, 0x02, 0x03, 0x99.
- Lock timeout: with LOCK_TIMEOUT=8, requester 0 sends 0x01 (last=0) then goes silent; requester 1 requests 0x55 → 0x55 is transferred ≥8 IDLE cycles later; `err` stays 0.
- Transfer timeout: with TIMEOUT=16, `tx_st` held 0 → `tx_rq` drops after 16 cycles, `err`=1 and stays 1; the next request from requester 2 (0x77) completes normally.
- Reset mid-transfer: assert `reset` while in DN_REQ → next cycle `tx_rq`=0, `req_st`=0, `grant`=0, `err`=0; the following request is granted to requester 0 first when multiple are pending.
